// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arbiter
//  Purpose  : Round-robin sharing of one 32-bit left shifter by two
//             requesters, with a registered result and per-requester responses.
//  Revision : 1.0
// ============================================================================
module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic [DATA_W-1:0]  resp0_data,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic [DATA_W-1:0]  resp1_data,
    output logic               busy,
    output logic               grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last_grant;
    logic                 r_owner;
    logic [DATA_W-1:0]    r_opa;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [DATA_W-1:0]    r_result;
    logic [DATA_W-1:0]    w_shifted;
    logic                 w_any;
    logic                 w_win;
    logic                 w_accept;
    logic                 w_idle;
    logic                 w_hold;

    assign w_any  = req0_valid | req1_valid;
    // Under contention the requester that did not win last time goes next.
    assign w_win  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_idle = (r_state == IDLE);
    assign w_hold = (r_state == HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: w_state_nxt = HOLD;
            HOLD: begin
                if (r_owner ? resp1_ready : resp0_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_opa        <= '0;
            r_shamt      <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_opa        <= w_win ? req1_data  : req0_data;
                r_shamt      <= w_win ? req1_shamt : req0_shamt;
                r_owner      <= w_win;
                r_last_grant <= w_win;
            end
            if (r_state == SHIFT) begin
                r_result <= w_shifted;
            end
        end
    end

    // The shifter only ever sees the latched operands.
    alu_SLL u_sll (
        .a     (r_opa),
        .shamt (r_shamt),
        .y     (w_shifted)
    );

    // Ready is gated by reset so nothing is offered while reset is held.
    assign req0_ready  = reset_n & w_idle & req0_valid & ~w_win;
    assign req1_ready  = reset_n & w_idle & req1_valid &  w_win;
    assign resp0_valid = w_hold & ~r_owner;
    assign resp1_valid = w_hold &  r_owner;
    assign resp0_data  = resp0_valid ? r_result : '0;
    assign resp1_data  = resp1_valid ? r_result : '0;
    assign busy        = ~w_idle;
    assign grant_id    = ~w_idle & r_owner;

endmodule

// ============================================================================
//  Module   : alu_SLL
//  Purpose  : 32-bit logical left shift, zero fill.
//  Revision : 1.0
// ============================================================================
module alu_SLL (
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);
    assign y = a << shamt;
endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// Testbench for shift_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic [4:0]  req0_shamt = '0, req1_shamt = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp0_data, resp1_data;
    logic        busy, grant_id;

    always #5 clock = ~clock;

    shift_arbiter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_shamt  (req0_shamt),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_shamt  (req1_shamt),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_data  (resp0_data),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_data  (resp1_data),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Which requester wins when the block is idle.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    // Transaction model: one operation in flight, age counts cycles since accept.
    logic        m_busy  = 1'b0;
    logic        m_owner = 1'b0;
    logic        m_last  = 1'b1;
    logic [31:0] m_res   = '0;
    int          m_age   = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_res   <= '0;
            m_age   <= 0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy  <= 1'b1;
                m_owner <= pick(req0_valid, req1_valid, m_last);
                m_last  <= pick(req0_valid, req1_valid, m_last);
                m_age   <= 1;
                m_res   <= pick(req0_valid, req1_valid, m_last) ? (req1_data << req1_shamt)
                                                                : (req0_data << req0_shamt);
            end
        end else if (m_age >= 2 && (m_owner ? resp1_ready : resp0_ready)) begin
            m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    bit mon_en = 0;
    always @(negedge clock) begin
        if (mon_en) begin
            chk("m_req0_ready", req0_ready,
                reset_n && !m_busy && req0_valid && !pick(req0_valid, req1_valid, m_last));
            chk("m_req1_ready", req1_ready,
                reset_n && !m_busy && req1_valid && pick(req0_valid, req1_valid, m_last));
            chk("m_busy", busy, m_busy);
            if (m_busy) chk("m_grant_id", grant_id, m_owner);
            chk("m_resp0_valid", resp0_valid, m_busy && m_age >= 2 && !m_owner);
            chk("m_resp1_valid", resp1_valid, m_busy && m_age >= 2 && m_owner);
            chk("m_resp0_data", resp0_data, (m_busy && m_age >= 2 && !m_owner) ? m_res : 32'h0);
            chk("m_resp1_data", resp1_data, (m_busy && m_age >= 2 && m_owner) ? m_res : 32'h0);
        end
    end

    task automatic set_req(input bit id, input logic v, input logic [31:0] d, input logic [4:0] s);
        if (id) begin
            req1_valid = v; req1_data = d; req1_shamt = s;
        end else begin
            req0_valid = v; req0_data = d; req0_shamt = s;
        end
    endtask

    // Issue one request alone; returns the response data and its latency in cycles after accept.
    task automatic issue(input bit id, input logic [31:0] d, input logic [4:0] s,
                         output logic [31:0] res, output int lat);
        bit ok;
        @(posedge clock); #1;
        set_req(id, 1'b1, d, s);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clock); #1;
        set_req(id, 1'b0, d, s);
        res = '0;
        lat = 0;
        ok  = 0;
        for (int n = 1; n <= 10 && !ok; n++) begin
            @(negedge clock);
            if (id ? resp1_valid : resp0_valid) begin
                ok  = 1;
                lat = n;
                res = id ? resp1_data : resp0_data;
            end
        end
        if (!ok) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] hold_d;
        int          lat;
        bit          ok;
        bit          gw;
        int          bcnt, vcnt, hs;
        bit          a0, a1;

        #1;
        mon_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_data", resp1_data, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Single requester, every shift amount.
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int s = 0; s < 32; s++) begin
            issue(0, 32'h1, s[4:0], res, lat);
            chk("walk_data", res, 32'h1 << s);
            chk("walk_latency", lat, 2);
            chk("walk_resp1_idle", resp1_valid, 0);
        end

        // Leave last_grant at 1 so requester 0 wins the first contention.
        issue(1, 32'h10, 5'd3, res, lat);
        chk("pre_cont_data", res, 32'h80);

        // Contention: grants must alternate 0,1,0,1.
        @(posedge clock); #1;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 5'd4);
        set_req(1, 1'b1, 32'h8000_0001, 5'd1);
        for (int g = 0; g < 4; g++) begin
            ok = 0;
            gw = 0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clock);
                if (req0_ready || req1_ready) begin
                    ok = 1;
                    gw = req1_ready;
                end
            end
            if (!ok) chk("cont_accept_timeout", 0, 1);
            chk("cont_order", gw, g % 2);
            chk("cont_loser_ready", gw ? req0_ready : req1_ready, 0);
            ok = 0;
            for (int n = 0; n < 10 && !ok; n++) begin
                @(negedge clock);
                if (resp0_valid || resp1_valid) begin
                    ok = 1;
                    chk("cont_data", gw ? resp1_data : resp0_data,
                        gw ? 32'h0000_0002 : 32'hFFFF_FFF0);
                end
            end
            if (!ok) chk("cont_resp_timeout", 0, 1);
        end
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on response 1 while requester 0 waits.
        resp1_ready = 1'b0;
        @(posedge clock); #1;
        set_req(1, 1'b1, 32'h1234_5678, 5'd8);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            ok = req1_ready;
        end
        if (!ok) chk("bp_accept_timeout", 0, 1);
        @(posedge clock); #1;
        req1_valid = 1'b0;
        set_req(0, 1'b1, 32'h0000_000F, 5'd2);
        ok = 0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clock);
            ok = resp1_valid;
        end
        if (!ok) chk("bp_resp_timeout", 0, 1);
        hold_d = resp1_data;
        chk("bp_data", hold_d, 32'h3456_7800);
        chk("bp_req0_blocked", req0_ready, 0);
        repeat (4) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk("bp_valid_stable", resp1_valid, 1);
            chk("bp_data_stable", resp1_data, hold_d);
            chk("bp_req0_blocked", req0_ready, 0);
        end
        @(posedge clock); #1;
        resp1_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_valid", resp1_valid, 1);
        chk("bp_release_req0", req0_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("bp_after_hs_req0_ready", req0_ready, 1);
        chk("bp_after_hs_resp1", resp1_valid, 0);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        ok = 0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clock);
            if (resp0_valid) begin
                ok = 1;
                chk("bp_req0_data", resp0_data, 32'h0000_003C);
            end
        end
        if (!ok) chk("bp_req0_timeout", 0, 1);

        // Arithmetic boundaries.
        issue(0, 32'hA5A5_A5A5, 5'd0, res, lat);
        chk("bound_shamt0", res, 32'hA5A5_A5A5);
        issue(1, 32'h0000_0003, 5'd31, res, lat);
        chk("bound_shamt31", res, 32'h8000_0000);

        // Asynchronous reset while in SHIFT.
        @(posedge clock); #1;
        set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd4);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clock);
            ok = req0_ready;
        end
        if (!ok) chk("rst_accept_timeout", 0, 1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        chk("rst_pre_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant_id, 0);
        chk("rst_mid_resp0_valid", resp0_valid, 0);
        chk("rst_mid_resp0_data", resp0_data, 0);
        chk("rst_mid_resp1_valid", resp1_valid, 0);
        chk("rst_mid_req0_ready", req0_ready, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("rst_no_stale", resp0_valid | resp1_valid, 0);
        end
        issue(1, 32'h0000_0001, 5'd5, res, lat);
        chk("rst_after_req1", res, 32'h0000_0020);
        issue(0, 32'h0000_0007, 5'd1, res, lat);
        chk("rst_after_req0", res, 32'h0000_000E);

        // resp0_ready high before the request: one HOLD cycle, two busy cycles.
        @(posedge clock); #1;
        set_req(0, 1'b1, 32'h0000_0005, 5'd3);
        @(negedge clock);
        chk("early_accept", req0_ready, 1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        bcnt = 0;
        vcnt = 0;
        repeat (6) begin
            @(negedge clock);
            bcnt += int'(busy);
            vcnt += int'(resp0_valid);
        end
        chk("early_busy_cycles", bcnt, 2);
        chk("early_valid_cycles", vcnt, 1);

        // Randomized traffic; requesters hold valid until accepted.
        hs = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) hs++;
            @(posedge clock); #1;
            if (!req0_valid || a0) begin
                req0_valid = ($urandom % 3) != 0;
                req0_data  = $urandom;
                req0_shamt = 5'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom % 3) != 0;
                req1_data  = $urandom;
                req1_shamt = 5'($urandom);
            end
            resp0_ready = $urandom % 2;
            resp1_ready = $urandom % 2;
        end
        chk("rand_progress", hs > 20, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
